// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: FSM state codes and the counter-width helper.
package key_pkg;

  // FSM state codes, kept as plain constants so other blocks can decode them.
  localparam logic [1:0] UP      = 2'd0;
  localparam logic [1:0] WAIT_DN = 2'd1;
  localparam logic [1:0] DOWN    = 2'd2;
  localparam logic [1:0] WAIT_UP = 2'd3;

  typedef enum logic [1:0] {
    StUp     = UP,
    StWaitDn = WAIT_DN,
    StDown   = DOWN,
    StWaitUp = WAIT_UP
  } key_state_e;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned w;
    v = (value > 0) ? value - 1 : 0;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for asynchronous inputs, with a per-bit reset value.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Shift the raw input through the chain; stage 0 is the metastability catcher.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= rst_val;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Pushbutton conditioner: synchronizes KEY_raw, qualifies each level change over
// DEBOUNCE_CYCLES stable samples and emits a clean level, edge pulses and a toggle bit.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic KEY_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
);

  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic PRESSED_LVL  = ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic RELEASED_LVL = ~PRESSED_LVL;

  logic key_s;
  logic pressed;

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             toggle_q, toggle_d;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES),
    .WIDTH      (1)
  ) u_sync (
    .clk    (CLOCK_50),
    .reset  (reset),
    .rst_val(RELEASED_LVL),
    .d      (KEY_raw),
    .q      (key_s)
  );

  assign pressed = (key_s == PRESSED_LVL);

  // Next-state logic: a candidate level must be seen on DEBOUNCE_CYCLES consecutive
  // samples; any sample back at the stable level abandons the candidate.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    unique case (state_q)
      StUp: begin
        if (pressed) begin
          state_d = StWaitDn;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      StWaitDn: begin
        if (!pressed) begin
          state_d = StUp;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = StDown;
          cnt_d    = '0;
          level_d  = PRESSED_LVL;
          press_d  = 1'b1;
          toggle_d = ~toggle_q;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      StDown: begin
        if (!pressed) begin
          state_d = StWaitUp;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      StWaitUp: begin
        if (pressed) begin
          state_d = StDown;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = StUp;
          cnt_d     = '0;
          level_d   = RELEASED_LVL;
          release_d = 1'b1;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = StUp;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers; reset forces the released idle condition
  // without producing any pulse.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= StUp;
      cnt_q     <= '0;
      level_q   <= RELEASED_LVL;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_toggle  = toggle_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, active-low key).
module tb_key_debouncer;

  localparam int D = 4;
  localparam int S = 2;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  logic KEY_raw  = 1'b1;
  logic key_level, key_press, key_release, key_toggle;

  int compared   = 0;
  int mismatched = 0;

  key_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .KEY_raw    (KEY_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle)
  );

  always #2 CLOCK_50 = ~CLOCK_50;

  // Reference model: raw input delayed by S samples, then a run-length rule --
  // D consecutive samples opposite the accepted level flip it.
  typedef struct {
    logic [S-1:0] sync;
    logic         level;
    logic         press;
    logic         rel;
    logic         toggle;
    int           run;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur, logic raw, logic rst);
    model_t n;
    logic   sample;
    n       = cur;
    n.press = 1'b0;
    n.rel   = 1'b0;
    if (rst) begin
      n.sync   = '1;
      n.level  = 1'b1;
      n.toggle = 1'b0;
      n.run    = 0;
      return n;
    end
    sample = cur.sync[S-1];
    n.sync = {cur.sync[S-2:0], raw};
    if (sample != cur.level) begin
      n.run = cur.run + 1;
      if (n.run == D) begin
        n.level = sample;
        n.run   = 0;
        if (sample == 1'b0) begin
          n.press  = 1'b1;
          n.toggle = ~cur.toggle;
        end else begin
          n.rel = 1'b1;
        end
      end
    end else begin
      n.run = 0;
    end
    return n;
  endfunction

  always @(posedge CLOCK_50) m <= model_next(m, KEY_raw, reset);

  // Drive one cycle of stimulus and land on the following falling edge for sampling.
  task automatic cyc(input logic raw);
    KEY_raw = raw;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc(1'b1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1;
    repeat (3) cyc(1'b0);
    compared++;
    if ({key_level, key_press, key_release, key_toggle} !== 4'b1000) begin
      mismatched++;
      $display("FAIL reset_vals got %b want 1000",
               {key_level, key_press, key_release, key_toggle});
    end
    reset = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0);
      compared++;
      if ({key_level, key_press, key_release, key_toggle} !==
          {m.level, m.press, m.rel, m.toggle}) begin
        mismatched++;
        $display("FAIL reset_run cyc %0d got %b want %b", i,
                 {key_level, key_press, key_release, key_toggle},
                 {m.level, m.press, m.rel, m.toggle});
      end
      if (key_press && lat == 0) lat = i;
    end
    compared++;
    if (lat != S + D) begin
      mismatched++;
      $display("FAIL reset_latency got %0d want %0d", lat, S + D);
    end
    compared++;
    if (key_level !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_level_held got %b want 0", key_level);
    end
    repeat (10) cyc(1'b1);
  endtask

  task automatic test_clean_press();
    int np, nr;
    np = 0;
    nr = 0;
    do_reset(2);
    for (int i = 0; i < 32; i++) begin
      cyc((i < 20) ? 1'b0 : 1'b1);
      compared++;
      if ({key_level, key_press, key_release, key_toggle} !==
          {m.level, m.press, m.rel, m.toggle}) begin
        mismatched++;
        $display("FAIL clean cyc %0d got %b want %b", i,
                 {key_level, key_press, key_release, key_toggle},
                 {m.level, m.press, m.rel, m.toggle});
      end
      np += int'(key_press);
      nr += int'(key_release);
    end
    compared++;
    if (np != 1 || nr != 1 || key_toggle !== 1'b1) begin
      mismatched++;
      $display("FAIL clean_counts got press=%0d rel=%0d tgl=%b want 1 1 1", np, nr, key_toggle);
    end
  endtask

  task automatic test_bounce();
    int npb, lat;
    npb = 0;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(((i / 2) % 2 == 0) ? 1'b0 : 1'b1);
      npb += int'(key_press) + int'(key_release);
    end
    compared++;
    if (npb != 0) begin
      mismatched++;
      $display("FAIL bounce_quiet got %0d pulses want 0", npb);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0);
      compared++;
      if ({key_level, key_press, key_release, key_toggle} !==
          {m.level, m.press, m.rel, m.toggle}) begin
        mismatched++;
        $display("FAIL bounce_hold cyc %0d got %b want %b", i,
                 {key_level, key_press, key_release, key_toggle},
                 {m.level, m.press, m.rel, m.toggle});
      end
      if (key_press && lat == 0) lat = i;
    end
    compared++;
    if (lat != S + D) begin
      mismatched++;
      $display("FAIL bounce_latency got %0d want %0d", lat, S + D);
    end
    repeat (10) cyc(1'b1);
  endtask

  task automatic test_glitch();
    int np, lat;
    np  = 0;
    lat = 0;
    for (int i = 0; i < 13; i++) begin
      cyc((i < 3) ? 1'b0 : 1'b1);
      np += int'(key_press) + int'(key_release);
      compared++;
      if (key_level !== 1'b1) begin
        mismatched++;
        $display("FAIL glitch_level cyc %0d got %b want 1", i, key_level);
      end
    end
    compared++;
    if (np != 0) begin
      mismatched++;
      $display("FAIL glitch_pulses got %0d want 0", np);
    end
    // A following clean press must take the full qualification time from idle.
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0);
      if (key_press && lat == 0) lat = i;
    end
    compared++;
    if (lat != S + D) begin
      mismatched++;
      $display("FAIL glitch_then_press latency got %0d want %0d", lat, S + D);
    end
    repeat (10) cyc(1'b1);
  endtask

  task automatic test_multi();
    int  np, nr;
    logic [2:0] seq;
    np = 0;
    nr = 0;
    seq = '0;
    do_reset(2);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(8, 15)) begin
        cyc(1'b0);
        np += int'(key_press);
        nr += int'(key_release);
      end
      seq[k] = key_toggle;
      repeat ($urandom_range(8, 15)) begin
        cyc(1'b1);
        np += int'(key_press);
        nr += int'(key_release);
      end
    end
    compared++;
    if (seq !== 3'b101 || np != 3 || nr != 3) begin
      mismatched++;
      $display("FAIL multi got tgl=%b press=%0d rel=%0d want 101 3 3", seq, np, nr);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    lat = 0;
    repeat (10) cyc(1'b0);
    compared++;
    if (key_level !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_down got %b want 0", key_level);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0);
      compared++;
      if (key_level !== 1'b1 || key_release !== 1'b0 || key_press !== 1'b0) begin
        mismatched++;
        $display("FAIL mid_reset cyc %0d got lvl=%b rel=%b prs=%b want 1 0 0", i,
                 key_level, key_release, key_press);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0);
      if (key_press && lat == 0) lat = i;
    end
    compared++;
    if (lat != S + D) begin
      mismatched++;
      $display("FAIL mid_repress latency got %0d want %0d", lat, S + D);
    end
    repeat (10) cyc(1'b1);
  endtask

  task automatic test_random();
    logic v;
    for (int seg = 0; seg < 120; seg++) begin
      v = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 9)) begin
        cyc(v);
        compared++;
        if ({key_level, key_press, key_release, key_toggle} !==
            {m.level, m.press, m.rel, m.toggle} || (key_press && key_release)) begin
          mismatched++;
          $display("FAIL random seg %0d got %b want %b", seg,
                   {key_level, key_press, key_release, key_toggle},
                   {m.level, m.press, m.rel, m.toggle});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_multi();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
